vga_timing: RTL
===============

# vga_timing

Pixel-timing generator and output stage for the console's video path. Produces the x/y pixel coordinates consumed by the text and sprite renderers, and takes back their combinational 1-bit r/g/b. Drives registered, blanked colour and HSYNC/VSYNC to the VGA connector, with both aligned to the same pixel. Also provides a frame-start pulse and a frame counter for game-logic pacing.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  synchronous, active-low reset
- r_in, g_in, b_in  in  1 each  renderer colour for the current x/y (combinational from x/y)
- x  out  10  horizontal counter value, 0..H_TOTAL-1 (H_TOTAL = sum of H_*)
- y  out  10  vertical counter value, 0..V_TOTAL-1
- active  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- pix_tick  out  1  pixel-clock enable; all pixel-rate outputs change only on clk edges where it is high
- r, g, b  out  1 each  registered colour, forced 0 outside active video
- hsync, vsync  out  1 each  sync outputs, aligned with r/g/b
- frame_start  out  1  one-clk pulse while x=0, y=0 is presented
- frame_cnt  out  16  completed-frame counter, wraps

## Operation
- Internal h/v counters advance by one per pix_tick.
  - h wraps H_TOTAL-1 -> 0.
  - v increments on h wrap and wraps V_TOTAL-1 -> 0.
- Stage 0, registered on each tick: x, y, active, frame_start.
- Stage 1, registered one tick later:
  - r = r_in & active; same for g and b.
  - hsync asserted (= SYNC_POL) for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vsync asserted for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - hsync and vsync are computed from the stage-0 x/y, so they stay aligned with the colour of the same pixel.
- frame_cnt increments by 1 mod 2^16 on the tick that presents x=H_TOTAL-1, y=V_TOTAL-1.
- frame_start is high only during the clk cycle in which x=0, y=0 first appear. It never stays high across a non-tick cycle.
- Width rule: every counter is 10 bits. H_TOTAL and V_TOTAL must be ≤ 1024; this is checked by an elaboration-time assertion.

## Timing
- Reset values, while rst_n is sampled low:
  - x=0, y=0, active=0, frame_start=0, frame_cnt=0
  - r=g=b=0
  - hsync = vsync = ~SYNC_POL
  - internal h=v=0, divider=0
- First tick after release presents x=0, y=0, active=1, frame_start=1.
- Latency: x/y -> r/g/b/hsync/vsync is exactly 1 tick.
- Reset asserted mid-frame takes effect at the next clk edge and returns all state to reset values. There is no partial-frame completion and no frame_cnt increment.
- Simultaneous h and v wrap (last pixel of the frame): y returns to 0 on the same tick that x returns to 0.

## Configuration
- VGA_PIX_DIV_EN defined:
  - pix_tick comes from a divide-by-2 toggle flop, for a 50 MHz clk giving 25 MHz pixels.
  - pix_tick is low on the first clk edge after release and high on the second, then alternates.
  - Outputs hold between ticks.
- VGA_PIX_DIV_EN undefined:
  - pix_tick is constant 1, for clk already at pixel rate.
  - The first edge after release is a tick.

## Test plan
- Reset, then 2 ticks: x=0→1, y=0, active=1; frame_start pulses once for exactly one clk; hsync=vsync=1 (SYNC_POL=0).
- Run to x=656: hsync falls at stage 1 one tick later; it stays low for exactly 96 ticks and rises when x=752 is at stage 1.
- Run a full frame (800×525 ticks): vsync low for exactly 1600 ticks (2 lines); frame_cnt=1 after the tick presenting (799,524); x=0, y=0 follow.
- Drive r_in=g_in=b_in=1 constantly: r/g/b high only for pixels with x<640, y<480 (1 tick later); 0 at x=640 and y=480.
- Assert rst_n=0 at (300,200) for one clk: every output equals its reset value on the next edge; frame_cnt stays unchanged at its reset value of 0; restart presents (0,0).
- With VGA_PIX_DIV_EN: x increments every 2 clk, and outputs hold on non-tick cycles. Without it: x increments every clk.

Source files
------------

// File: rtl/vga_timing_if.sv
// Pixel-side bus of vga_timing: renderer colour in, coordinates, blanked colour,
// syncs and frame pacing out.
interface vga_timing_if;
  logic        r_in;
  logic        g_in;
  logic        b_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        active;
  logic        pix_tick;
  logic        r;
  logic        g;
  logic        b;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    input  r_in, g_in, b_in,
    output x, y, active, pix_tick, r, g, b, hsync, vsync, frame_start, frame_cnt
  );

  modport slave (
    output r_in, g_in, b_in,
    input  x, y, active, pix_tick, r, g, b, hsync, vsync, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing.sv
// VGA pixel-timing generator with registered, blanked colour and aligned syncs.
// Optional feature macro: VGA_PIX_DIV_EN (pixel enable = clk divided by 2).

// Elaboration-time guard: both totals must fit the 10-bit counters.
module vga_timing_chk #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
);
  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_oversize
    $error("vga_timing: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end
endmodule

module vga_timing #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  vga_timing_chk #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) u_chk ();

  logic        tick_s;
  logic        h_wrap_s;
  logic [9:0]  h_nxt_s;
  logic [9:0]  v_nxt_s;
  logic [9:0]  h_r;
  logic [9:0]  v_r;
  logic [9:0]  x_r;
  logic [9:0]  y_r;
  logic        active_r;
  logic        fs_r;
  logic [15:0] frame_cnt_r;
  logic        r_r;
  logic        g_r;
  logic        b_r;
  logic        hsync_r;
  logic        vsync_r;

`ifdef VGA_PIX_DIV_EN
  logic div_r;

  // Toggle flop: low on the first edge after reset, ticks on the second.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_r <= 1'b0;
    end else begin
      div_r <= ~div_r;
    end
  end

  assign tick_s = div_r;
`else
  assign tick_s = 1'b1;
`endif

  // Next raster position; v steps only when h wraps.
  always_comb begin
    h_wrap_s = (h_r == H_LAST);
    h_nxt_s  = h_r + 10'd1;
    v_nxt_s  = v_r;
    if (h_wrap_s) begin
      h_nxt_s = 10'd0;
      if (v_r == V_LAST) begin
        v_nxt_s = 10'd0;
      end else begin
        v_nxt_s = v_r + 10'd1;
      end
    end else begin
      h_nxt_s = h_r + 10'd1;
    end
  end

  // Raster counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_r <= 10'd0;
      v_r <= 10'd0;
    end else if (tick_s) begin
      h_r <= h_nxt_s;
      v_r <= v_nxt_s;
    end else begin
      h_r <= h_r;
      v_r <= v_r;
    end
  end

  // Stage 0: present coordinates; frame_start is dropped on any non-tick edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r         <= 10'd0;
      y_r         <= 10'd0;
      active_r    <= 1'b0;
      fs_r        <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else if (tick_s) begin
      x_r      <= h_r;
      y_r      <= v_r;
      active_r <= (h_r < H_ACT) && (v_r < V_ACT);
      fs_r     <= (h_r == 10'd0) && (v_r == 10'd0);
      if (h_wrap_s && (v_r == V_LAST)) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end else begin
      fs_r <= 1'b0;
    end
  end

  // Stage 1: blanked colour and syncs, all derived from the same stage-0 pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_r     <= 1'b0;
      g_r     <= 1'b0;
      b_r     <= 1'b0;
      hsync_r <= ~SYNC_POL;
      vsync_r <= ~SYNC_POL;
    end else if (tick_s) begin
      r_r     <= bus.r_in & active_r;
      g_r     <= bus.g_in & active_r;
      b_r     <= bus.b_in & active_r;
      hsync_r <= ((x_r >= H_SS) && (x_r <= H_SE)) ? SYNC_POL : ~SYNC_POL;
      vsync_r <= ((y_r >= V_SS) && (y_r <= V_SE)) ? SYNC_POL : ~SYNC_POL;
    end else begin
      r_r     <= r_r;
      g_r     <= g_r;
      b_r     <= b_r;
      hsync_r <= hsync_r;
      vsync_r <= vsync_r;
    end
  end

  assign bus.pix_tick    = tick_s;
  assign bus.x           = x_r;
  assign bus.y           = y_r;
  assign bus.active      = active_r;
  assign bus.frame_start = fs_r;
  assign bus.frame_cnt   = frame_cnt_r;
  assign bus.r           = r_r;
  assign bus.g           = g_r;
  assign bus.b           = b_r;
  assign bus.hsync       = hsync_r;
  assign bus.vsync       = vsync_r;
endmodule
